// File: rtl/uart_rx_ctrl.sv
// UART receiver frame sequencer: start detection, oversampling/bit counters,
// one-cycle check/shift strobes and the per-frame Data_Valid / Rx_Err verdict.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               PAR_EN,
  input  logic               Start_Err,
  input  logic               Par_Err,
  input  logic               Stop_Err,
  output logic [PRESC_W-1:0] Edge_Cnt,
  output logic [3:0]         Bit_Cnt,
  output logic               Samp_EN,
  output logic               Deser_EN,
  output logic               Start_CHK_EN,
  output logic               Par_CHK_EN,
  output logic               Stop_CHK_EN,
  output logic               Data_Valid,
  output logic               Rx_Err
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [3:0]         LAST_DATA_BIT = 4'(DATA_WIDTH);
  localparam logic [PRESC_W-1:0] P8            = PRESC_W'(8);
  localparam logic [PRESC_W-1:0] P16           = PRESC_W'(16);
  localparam logic [PRESC_W-1:0] P32           = PRESC_W'(32);

  state_t             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] edge_d, mid_d, last_q;
  logic [3:0]         bit_d;
  logic               par_en_q, par_en_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               start_pend_q, par_pend_q, stop_pend_q;
  logic               wrap;
  logic               samp_d, deser_d, start_chk_d, par_chk_d, stop_chk_d;
  logic               dv_d, rx_err_d;

  assign last_q = presc_q - PRESC_W'(1);
  assign wrap   = (Edge_Cnt == last_q);

  always_comb begin
    state_d  = state_q;
    edge_d   = Edge_Cnt;
    bit_d    = Bit_Cnt;
    presc_d  = presc_q;
    par_en_d = par_en_q;
    done_d   = 1'b0;
    // Check results arrive one cycle after their strobe; fold them into the
    // latch then, since the checkers need not hold them until the bit ends.
    err_d    = err_q | (start_pend_q & Start_Err) | (par_pend_q & Par_Err)
             | (stop_pend_q & Stop_Err);

    if (state_q != IDLE) begin
      edge_d = wrap ? '0 : Edge_Cnt + PRESC_W'(1);
      if (wrap) bit_d = Bit_Cnt + 4'd1;
    end

    case (state_q)
      IDLE: begin
        if (!RX_IN) begin
          state_d  = START;
          edge_d   = '0;
          bit_d    = '0;
          presc_d  = (Prescale == P8 || Prescale == P16 || Prescale == P32) ? Prescale : P8;
          par_en_d = PAR_EN;
          err_d    = 1'b0;
        end
      end
      START: begin
        if (wrap) begin
          if (err_d) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (wrap && Bit_Cnt == LAST_DATA_BIT) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (wrap) state_d = STOP;
      end
      STOP: begin
        if (wrap) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) bit_d = '0;

    // Strobes are computed from next-state values so they line up with the
    // registered Edge_Cnt they refer to.
    mid_d       = (presc_d >> 1) + PRESC_W'(2);
    samp_d      = (state_d != IDLE);
    deser_d     = (state_d == DATA)   && (edge_d == mid_d);
    start_chk_d = (state_d == START)  && (edge_d == mid_d);
    par_chk_d   = (state_d == PARITY) && (edge_d == mid_d);
    stop_chk_d  = (state_d == STOP)   && (edge_d == mid_d);
    dv_d        = (state_q == IDLE) && done_q && !err_q;
    rx_err_d    = (state_q == IDLE) && done_q && err_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      presc_q      <= P8;
      par_en_q     <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      start_pend_q <= 1'b0;
      par_pend_q   <= 1'b0;
      stop_pend_q  <= 1'b0;
      Edge_Cnt     <= '0;
      Bit_Cnt      <= '0;
      Samp_EN      <= 1'b0;
      Deser_EN     <= 1'b0;
      Start_CHK_EN <= 1'b0;
      Par_CHK_EN   <= 1'b0;
      Stop_CHK_EN  <= 1'b0;
      Data_Valid   <= 1'b0;
      Rx_Err       <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      par_en_q     <= par_en_d;
      err_q        <= err_d;
      done_q       <= done_d;
      start_pend_q <= Start_CHK_EN;
      par_pend_q   <= Par_CHK_EN;
      stop_pend_q  <= Stop_CHK_EN;
      Edge_Cnt     <= edge_d;
      Bit_Cnt      <= bit_d;
      Samp_EN      <= samp_d;
      Deser_EN     <= deser_d;
      Start_CHK_EN <= start_chk_d;
      Par_CHK_EN   <= par_chk_d;
      Stop_CHK_EN  <= stop_chk_d;
      Data_Valid   <= dv_d;
      Rx_Err       <= rx_err_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: directed frames push expected verdicts,
// a negedge monitor pops them on each Data_Valid / Rx_Err pulse.
module tb_uart_rx_ctrl;
  localparam int DW = 8;
  localparam int PW = 6;

  logic          CLK = 1'b0;
  logic          RST, RX_IN, PAR_EN, Start_Err, Par_Err, Stop_Err;
  logic [PW-1:0] Prescale;
  logic [PW-1:0] Edge_Cnt;
  logic [3:0]    Bit_Cnt;
  logic          Samp_EN, Deser_EN, Start_CHK_EN, Par_CHK_EN, Stop_CHK_EN;
  logic          Data_Valid, Rx_Err;

  uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .Start_Err(Start_Err), .Par_Err(Par_Err), .Stop_Err(Stop_Err),
    .Edge_Cnt(Edge_Cnt), .Bit_Cnt(Bit_Cnt), .Samp_EN(Samp_EN), .Deser_EN(Deser_EN),
    .Start_CHK_EN(Start_CHK_EN), .Par_CHK_EN(Par_CHK_EN), .Stop_CHK_EN(Stop_CHK_EN),
    .Data_Valid(Data_Valid), .Rx_Err(Rx_Err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit is_err;
    int cyc;
    int nd;
    int np;
    int mid;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   last_idle = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_edge_cnt"},   int'(Edge_Cnt),     0);
    chk({tag, "_bit_cnt"},    int'(Bit_Cnt),      0);
    chk({tag, "_samp_en"},    int'(Samp_EN),      0);
    chk({tag, "_deser_en"},   int'(Deser_EN),     0);
    chk({tag, "_start_chk"},  int'(Start_CHK_EN), 0);
    chk({tag, "_par_chk"},    int'(Par_CHK_EN),   0);
    chk({tag, "_stop_chk"},   int'(Stop_CHK_EN),  0);
    chk({tag, "_data_valid"}, int'(Data_Valid),   0);
    chk({tag, "_rx_err"},     int'(Rx_Err),       0);
  endtask

  // FSM sees a low line at the end of the later of (drive cycle, idle cycle),
  // enters START next cycle, and reports one cycle after returning to IDLE.
  function automatic int fsm_start(input int d);
    return ((d > last_idle) ? d : last_idle) + 1;
  endfunction

  task automatic send_frame(input logic [7:0] data, input int p, input bit par,
                            input bit is_err, input int mid);
    int   start;
    exp_t e;
    start     = fsm_start(cyc);
    last_idle = start + p * (DW + 2 + int'(par));
    e.is_err  = is_err;
    e.cyc     = last_idle + 1;
    e.nd      = DW;
    e.np      = int'(par);
    e.mid     = mid;
    sb.push_back(e);
    RX_IN = 1'b0;
    tick(p);
    for (int i = 0; i < DW; i++) begin
      RX_IN = data[i];
      tick(p);
    end
    if (par) begin
      RX_IN = ^data;
      tick(p);
    end
    RX_IN = 1'b1;
    tick(p);
  endtask

  int nd = 0;
  int np = 0;
  always @(negedge CLK) begin
    int   nstb;
    exp_t e;
    if (!RST) begin
      nd = 0;
      np = 0;
    end else begin
      nstb = int'(Deser_EN) + int'(Start_CHK_EN) + int'(Par_CHK_EN) + int'(Stop_CHK_EN);
      if (nstb != 0) begin
        chk("strobe_onehot", nstb, 1);
        chk("strobe_samp_en", int'(Samp_EN), 1);
        if (sb.size() > 0) chk("strobe_edge_cnt", int'(Edge_Cnt), sb[0].mid);
      end
      if (Deser_EN) begin
        nd++;
        chk("deser_bit_cnt", int'(Bit_Cnt), nd);
      end
      if (Par_CHK_EN) np++;
      if (Data_Valid || Rx_Err) begin
        chk("dv_rxerr_exclusive", int'(Data_Valid & Rx_Err), 0);
        if (sb.size() == 0) begin
          chk("unexpected_pulse", cyc, -1);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind_rx_err", int'(Rx_Err), int'(e.is_err));
          chk("pulse_cycle", cyc, e.cyc);
          chk("deser_count", nd, e.nd);
          chk("par_chk_count", np, e.np);
        end
        nd = 0;
        np = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   start;
    exp_t e;
    RST = 1'b0; RX_IN = 1'b1; Prescale = PW'(8); PAR_EN = 1'b0;
    Start_Err = 1'b0; Par_Err = 1'b0; Stop_Err = 1'b0;
    #2;
    chk_zero("reset");
    tick(2);
    RST = 1'b1;
    tick(3);

    // P=8, no parity, clean frame
    send_frame(8'hA5, 8, 1'b0, 1'b0, 6);
    tick(10);

    // P=16 with parity error: frame still runs to the stop bit
    Prescale = PW'(16); PAR_EN = 1'b1; Par_Err = 1'b1;
    send_frame(8'h5A, 16, 1'b1, 1'b1, 10);
    tick(10);
    Par_Err = 1'b0; PAR_EN = 1'b0;

    // Start-bit glitch rejected after one bit time
    Prescale = PW'(8); Start_Err = 1'b1;
    start     = fsm_start(cyc);
    last_idle = start + 8;
    e.is_err = 1'b1; e.cyc = last_idle + 1; e.nd = 0; e.np = 0; e.mid = 6;
    sb.push_back(e);
    RX_IN = 1'b0;
    tick(3);
    RX_IN = 1'b1;
    tick(12);
    Start_Err = 1'b0;
    tick(2);

    // Stop error, then a back-to-back good frame
    Stop_Err = 1'b1;
    send_frame(8'h81, 8, 1'b0, 1'b1, 6);
    fork
      send_frame(8'h3C, 8, 1'b0, 1'b0, 6);
      begin tick(20); Stop_Err = 1'b0; end
    join
    tick(10);

    // Prescale change mid-frame is ignored until the next start
    Prescale = PW'(8);
    fork
      send_frame(8'h96, 8, 1'b0, 1'b0, 6);
      begin tick(30); Prescale = PW'(32); end
    join
    tick(10);
    send_frame(8'h3C, 32, 1'b0, 1'b0, 18);
    tick(10);

    // Illegal prescale falls back to 8
    Prescale = PW'(12);
    send_frame(8'h0F, 8, 1'b0, 1'b0, 6);
    tick(10);

    // Reset in the middle of data bit 4 aborts silently
    Prescale = PW'(8);
    start = fsm_start(cyc);
    RX_IN = 1'b0;
    tick(8);
    RX_IN = 1'b1;
    while (cyc < start + 35) tick(1);
    chk("abort_pre_bit_cnt", int'(Bit_Cnt), 4);
    chk("abort_pre_samp_en", int'(Samp_EN), 1);
    RST = 1'b0;
    #1;
    chk_zero("abort");
    tick(3);
    RST = 1'b1;
    last_idle = cyc;
    tick(4);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 6);
    tick(10);

    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
